// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day core: the set-mode state machine,
// field codes driven on field_o, blink timing and the BCD digit width.
package clock_pkg;

  localparam int DIGIT_W     = 4;
  localparam int BLINK_TICKS = 25;
  localparam int BLINK_CNT_W = $clog2(BLINK_TICKS);

  // Field codes as seen on field_o.
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_SEC  = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_HR   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_SEC,
    ST_SET_MIN,
    ST_SET_HR
  } state_e;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping modulo MAX+1. Counting (cnt_en_i) and inc_i
// both step up; carry_o flags the wrap of a counted step so the next field can
// advance on the same edge. inc_i never produces a carry: set-mode edits stay
// inside one field.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               cnt_en_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o,
  output logic               carry_o
);

  localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX / 10);
  localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX % 10);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               at_max, at_zero;

  assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign at_zero = (tens_q == '0) && (ones_q == '0);
  assign carry_o = cnt_en_i && at_max;
  assign tens_o  = tens_q;
  assign ones_o  = ones_q;

  // Next value: clear wins, then up-step, then down-step.
  always_comb begin
    // NOTE: default every output of a combinational block first so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear_i) begin
      tens_d = '0;
      ones_d = '0;
    end else if (cnt_en_i || inc_i) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == DIGIT_W'(9)) begin
        tens_d = tens_q + DIGIT_W'(1);
        ones_d = '0;
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end else if (dec_i) begin
      if (at_zero) begin
        tens_d = MAX_TENS;
        ones_d = MAX_ONES;
      end else if (ones_q == '0) begin
        tens_d = tens_q - DIGIT_W'(1);
        ones_d = DIGIT_W'(9);
      end else begin
        ones_d = ones_q - DIGIT_W'(1);
      end
    end
  end

  // Digit registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    if (reset_i) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/clock_time_core.sv
// Time-of-day core: divides clk_50mhz_i down to a centisecond tick, keeps
// HH:MM:SS.cc in BCD and provides a key-driven set mode with a blinking field.
// Build option TWELVE_HOUR_EN switches hours to 12/01..11 with a pm_o flag.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic               clk_50mhz_i,
  input  logic               reset_i,
  input  logic               set_mode_i,
  input  logic               sel_pulse_i,
  input  logic               inc_pulse_i,
  input  logic               dec_pulse_i,
  output logic [DIGIT_W-1:0] centisec_o,
  output logic [DIGIT_W-1:0] decisec_o,
  output logic [DIGIT_W-1:0] sec_o,
  output logic [DIGIT_W-1:0] decasec_o,
  output logic [DIGIT_W-1:0] min_o,
  output logic [DIGIT_W-1:0] decamin_o,
  output logic [DIGIT_W-1:0] hr_o,
  output logic [DIGIT_W-1:0] decahr_o,
  output logic [1:0]         field_o,
  output logic               blink_o,
  output logic               tick_o
`ifdef TWELVE_HOUR_EN
  ,
  output logic               pm_o
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0]          presc_q;
  logic                   presc_tc;
  state_e                 state_q;
  logic [BLINK_CNT_W-1:0] blink_cnt_q;
  logic                   cnt_en, cs_clear, adj_inc, adj_dec;
  logic                   cs_carry, sec_carry, min_carry;
  logic                   hr_up, hr_dn;
  logic [DIGIT_W-1:0]     hr_tens_q, hr_tens_d, hr_ones_q, hr_ones_d;

  assign presc_tc = (presc_q == PW'(DIV - 1));
  // Time advances only in RUN, and not on the edge that enters set mode so
  // the centisecond clear on entry cannot race a carry into seconds.
  assign cnt_en   = presc_tc && (state_q == ST_RUN) && !set_mode_i;
  assign cs_clear = (state_q == ST_RUN) && set_mode_i;
  // Opposing inc/dec in one cycle cancel out.
  assign adj_inc  = inc_pulse_i && !dec_pulse_i;
  assign adj_dec  = dec_pulse_i && !inc_pulse_i;

  // Free-running prescaler; its terminal count is the centisecond tick.
  always_ff @(posedge clk_50mhz_i) begin
    if (reset_i)       presc_q <= '0;
    else if (presc_tc) presc_q <= '0;
    else               presc_q <= presc_q + PW'(1);
  end

  bcd_mod_counter #(.MAX(99)) u_cs (
    .clk_i(clk_50mhz_i), .reset_i(reset_i), .clear_i(cs_clear), .cnt_en_i(cnt_en),
    .inc_i(1'b0), .dec_i(1'b0), .tens_o(decisec_o), .ones_o(centisec_o), .carry_o(cs_carry)
  );

  bcd_mod_counter #(.MAX(59)) u_sec (
    .clk_i(clk_50mhz_i), .reset_i(reset_i), .clear_i(1'b0), .cnt_en_i(cs_carry),
    .inc_i(adj_inc && (state_q == ST_SET_SEC)), .dec_i(adj_dec && (state_q == ST_SET_SEC)),
    .tens_o(decasec_o), .ones_o(sec_o), .carry_o(sec_carry)
  );

  bcd_mod_counter #(.MAX(59)) u_min (
    .clk_i(clk_50mhz_i), .reset_i(reset_i), .clear_i(1'b0), .cnt_en_i(sec_carry),
    .inc_i(adj_inc && (state_q == ST_SET_MIN)), .dec_i(adj_dec && (state_q == ST_SET_MIN)),
    .tens_o(decamin_o), .ones_o(min_o), .carry_o(min_carry)
  );

  // Minute carry and set-mode edits are mutually exclusive (RUN vs SET_HR).
  assign hr_up = min_carry || (adj_inc && (state_q == ST_SET_HR));
  assign hr_dn = adj_dec && (state_q == ST_SET_HR);

`ifdef TWELVE_HOUR_EN
  logic pm_q, pm_d;
  assign pm_o = pm_q;

  // 12-hour sequence 12,01..11; crossing 11<->12 flips AM/PM in both directions.
  always_comb begin
    hr_tens_d = hr_tens_q;
    hr_ones_d = hr_ones_q;
    pm_d      = pm_q;
    if (hr_up) begin
      if (hr_tens_q == 4'd1 && hr_ones_q == 4'd1) begin
        hr_ones_d = 4'd2;
        pm_d      = !pm_q;
      end else if (hr_tens_q == 4'd1 && hr_ones_q == 4'd2) begin
        hr_tens_d = 4'd0;
        hr_ones_d = 4'd1;
      end else if (hr_ones_q == 4'd9) begin
        hr_tens_d = 4'd1;
        hr_ones_d = 4'd0;
      end else begin
        hr_ones_d = hr_ones_q + 4'd1;
      end
    end else if (hr_dn) begin
      if (hr_tens_q == 4'd1 && hr_ones_q == 4'd2) begin
        hr_ones_d = 4'd1;
        pm_d      = !pm_q;
      end else if (hr_tens_q == 4'd0 && hr_ones_q == 4'd1) begin
        hr_tens_d = 4'd1;
        hr_ones_d = 4'd2;
      end else if (hr_ones_q == 4'd0) begin
        hr_tens_d = 4'd0;
        hr_ones_d = 4'd9;
      end else begin
        hr_ones_d = hr_ones_q - 4'd1;
      end
    end
  end

  // Hour registers; reset time is 12:00 AM.
  always_ff @(posedge clk_50mhz_i) begin
    if (reset_i) begin
      hr_tens_q <= 4'd1;
      hr_ones_q <= 4'd2;
      pm_q      <= 1'b0;
    end else begin
      hr_tens_q <= hr_tens_d;
      hr_ones_q <= hr_ones_d;
      pm_q      <= pm_d;
    end
  end
`else
  // 24-hour sequence 00..23, wrapping in both directions.
  always_comb begin
    hr_tens_d = hr_tens_q;
    hr_ones_d = hr_ones_q;
    if (hr_up) begin
      if (hr_tens_q == 4'd2 && hr_ones_q == 4'd3) begin
        hr_tens_d = 4'd0;
        hr_ones_d = 4'd0;
      end else if (hr_ones_q == 4'd9) begin
        hr_tens_d = hr_tens_q + 4'd1;
        hr_ones_d = 4'd0;
      end else begin
        hr_ones_d = hr_ones_q + 4'd1;
      end
    end else if (hr_dn) begin
      if (hr_tens_q == 4'd0 && hr_ones_q == 4'd0) begin
        hr_tens_d = 4'd2;
        hr_ones_d = 4'd3;
      end else if (hr_ones_q == 4'd0) begin
        hr_tens_d = hr_tens_q - 4'd1;
        hr_ones_d = 4'd9;
      end else begin
        hr_ones_d = hr_ones_q - 4'd1;
      end
    end
  end

  // Hour registers; reset time is 00.
  always_ff @(posedge clk_50mhz_i) begin
    if (reset_i) begin
      hr_tens_q <= 4'd0;
      hr_ones_q <= 4'd0;
    end else begin
      hr_tens_q <= hr_tens_d;
      hr_ones_q <= hr_ones_d;
    end
  end
`endif

  assign decahr_o = hr_tens_q;
  assign hr_o     = hr_ones_q;

  // Mode FSM with registered field_o, tick_o and blink_o.
  always_ff @(posedge clk_50mhz_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      field_o     <= FIELD_NONE;
      tick_o      <= 1'b0;
      blink_o     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      tick_o <= cnt_en;
      if (!set_mode_i) begin
        state_q <= ST_RUN;
        field_o <= FIELD_NONE;
      end else begin
        case (state_q)
          ST_RUN: begin
            state_q <= ST_SET_SEC;
            field_o <= FIELD_SEC;
          end
          ST_SET_SEC: if (sel_pulse_i) begin
            state_q <= ST_SET_MIN;
            field_o <= FIELD_MIN;
          end
          ST_SET_MIN: if (sel_pulse_i) begin
            state_q <= ST_SET_HR;
            field_o <= FIELD_HR;
          end
          ST_SET_HR: if (sel_pulse_i) begin
            state_q <= ST_SET_SEC;
            field_o <= FIELD_SEC;
          end
          default: begin
            state_q <= ST_RUN;
            field_o <= FIELD_NONE;
          end
        endcase
      end
      // Blink runs only while set mode persists; leaving or entering restarts it.
      if (state_q == ST_RUN || !set_mode_i) begin
        blink_cnt_q <= '0;
        blink_o     <= 1'b0;
      end else if (presc_tc) begin
        if (blink_cnt_q == BLINK_CNT_W'(BLINK_TICKS - 1)) begin
          blink_cnt_q <= '0;
          blink_o     <= !blink_o;
        end else begin
          blink_cnt_q <= blink_cnt_q + BLINK_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_time_core.sv
// Self-checking bench for clock_time_core (DIV = 10). A time-in-centiseconds
// reference model is compared against the DUT every cycle; directed tables and
// sequences cover the set-mode and rollover corner cases. Honours TWELVE_HOUR_EN.
module tb_clock_time_core;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DAY_CS  = 24 * 60 * 60 * 100;

  logic clk = 1'b0;
  logic rst, set_mode, sel, inc, dec;
  logic [3:0] centisec, decisec, sec, decasec, min, decamin, hr, decahr;
  logic [1:0] field;
  logic blink, tick, dut_pm;

  clock_time_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk_50mhz_i(clk), .reset_i(rst), .set_mode_i(set_mode), .sel_pulse_i(sel),
    .inc_pulse_i(inc), .dec_pulse_i(dec),
    .centisec_o(centisec), .decisec_o(decisec), .sec_o(sec), .decasec_o(decasec),
    .min_o(min), .decamin_o(decamin), .hr_o(hr), .decahr_o(decahr),
    .field_o(field), .blink_o(blink), .tick_o(tick)
`ifdef TWELVE_HOUR_EN
    , .pm_o(dut_pm)
`endif
  );

`ifndef TWELVE_HOUR_EN
  assign dut_pm = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: time held as plain integers, mode 0 = run, 1..3 = field.
  int m_hr = 0, m_min = 0, m_sec = 0, m_cs = 0;
  int m_presc = 0, m_mode = 0, m_bcnt = 0;
  bit m_blink = 0, m_tick = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] disp_hr(input int h24);
    int h;
`ifdef TWELVE_HOUR_EN
    h = (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    h = h24;
`endif
    return bcd2(h);
  endfunction

  function automatic bit pm_of(input int h24);
`ifdef TWELVE_HOUR_EN
    return h24 >= 12;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] dut_digits();
    return {decahr, hr, decamin, min, decasec, sec, decisec, centisec};
  endfunction

  function automatic logic [63:0] dut_state();
    return {27'b0, dut_digits(), field, blink, tick, dut_pm};
  endfunction

  function automatic logic [63:0] model_state();
    return {27'b0, disp_hr(m_hr), bcd2(m_min), bcd2(m_sec), bcd2(m_cs),
            2'(m_mode), m_blink, m_tick, pm_of(m_hr)};
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit sl, input bit i, input bit d);
    bit tk;
    int delta, old, total;
    if (r) begin
      m_hr = 0; m_min = 0; m_sec = 0; m_cs = 0;
      m_presc = 0; m_mode = 0; m_bcnt = 0; m_blink = 0; m_tick = 0;
      return;
    end
    tk      = (m_presc == DIV - 1);
    m_presc = (m_presc + 1) % DIV;
    delta   = (i && !d) ? 1 : ((d && !i) ? -1 : 0);
    old     = m_mode;
    m_tick  = 0;
    if (old == 0) begin
      if (s) m_cs = 0;
      else if (tk) begin
        total = ((((m_hr * 60) + m_min) * 60 + m_sec) * 100 + m_cs + 1) % DAY_CS;
        m_cs  = total % 100;
        m_sec = (total / 100) % 60;
        m_min = (total / 6000) % 60;
        m_hr  = total / 360000;
        m_tick = 1;
      end
    end else begin
      case (old)
        1: m_sec = (m_sec + delta + 60) % 60;
        2: m_min = (m_min + delta + 60) % 60;
        default: m_hr = (m_hr + delta + 24) % 24;
      endcase
    end
    if (!s) m_mode = 0;
    else if (old == 0) m_mode = 1;
    else if (sl) m_mode = old % 3 + 1;
    if (!s || old == 0) begin
      m_bcnt = 0; m_blink = 0;
    end else if (tk) begin
      m_bcnt++;
      if (m_bcnt == 25) begin
        m_bcnt = 0; m_blink = !m_blink;
      end
    end
  endtask

  // One clock: drive after the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input bit r, input bit s, input bit sl, input bit i, input bit d);
    rst = r; set_mode = s; sel = sl; inc = i; dec = d;
    @(posedge clk);
    model_edge(r, s, sl, i, d);
    @(negedge clk);
    check("cycle_vs_model", dut_state(), model_state());
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  // Set 59 s / 59 min, step hours down n_dec times from reset, run to .99 and
  // roll once; expect exp_h24:00:00.00 and a single tick pulse.
  task automatic preload_and_roll(input int n_dec, input int exp_h24);
    bit found;
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    for (int k = 0; k < n_dec; k++) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 1200; k++) begin
      if ({decisec, centisec} == 8'h99) begin
        found = 1;
        break;
      end
      step(0, 0, 0, 0, 0);
    end
    check("roll_reach_99", found, 1'b1);
    found = 0;
    for (int k = 0; k < DIV + 2; k++) begin
      step(0, 0, 0, 0, 0);
      if (tick) begin
        found = 1;
        break;
      end
    end
    check("roll_tick_seen", found, 1'b1);
    check("roll_digits", dut_digits(), {disp_hr(exp_h24), 24'h0});
    check("roll_pm", dut_pm, pm_of(exp_h24));
    step(0, 0, 0, 0, 0);
    check("roll_single_tick", tick, 1'b0);
  endtask

  typedef struct {
    bit s, sl, i, d;
    logic [1:0] f;
    int sec, min, hr;
  } vec_t;

  vec_t vec[13];

  initial begin
    bit seen, prev, cur_s;
    int n;

    vec[0]  = '{1, 0, 0, 0, 2'd1,  0,  0,  0};
    vec[1]  = '{1, 0, 0, 1, 2'd1, 59,  0,  0};
    vec[2]  = '{1, 0, 1, 0, 2'd1,  0,  0,  0};
    vec[3]  = '{1, 1, 1, 0, 2'd2,  1,  0,  0};
    vec[4]  = '{1, 0, 1, 1, 2'd2,  1,  0,  0};
    vec[5]  = '{1, 0, 1, 0, 2'd2,  1,  1,  0};
    vec[6]  = '{1, 0, 0, 1, 2'd2,  1,  0,  0};
    vec[7]  = '{1, 0, 0, 1, 2'd2,  1, 59,  0};
    vec[8]  = '{1, 1, 0, 0, 2'd3,  1, 59,  0};
    vec[9]  = '{1, 0, 0, 1, 2'd3,  1, 59, 23};
    vec[10] = '{1, 0, 1, 0, 2'd3,  1, 59,  0};
    vec[11] = '{1, 1, 0, 0, 2'd1,  1, 59,  0};
    vec[12] = '{0, 0, 1, 0, 2'd0,  2, 59,  0};

    rst = 1; set_mode = 0; sel = 0; inc = 0; dec = 0;

    // Reset state and first-tick latency.
    do_reset();
    check("reset_state", {dut_digits(), field, blink, tick},
          {disp_hr(0), 24'h0, 2'b00, 1'b0, 1'b0});
    check("reset_pm", dut_pm, 1'b0);
    for (int k = 1; k <= 9; k++) step(0, 0, 0, 0, 0);
    check("pre_first_tick", {centisec, tick}, {4'd0, 1'b0});
    step(0, 0, 0, 0, 0);
    check("first_tick", {centisec, tick}, {4'd1, 1'b1});
    step(0, 0, 0, 0, 0);
    check("tick_width", tick, 1'b0);
    for (int k = 12; k <= 1000; k++) step(0, 0, 0, 0, 0);
    check("one_second", dut_digits(), {disp_hr(0), 8'h00, 8'h01, 8'h00});

    // Set-mode edits from a table.
    do_reset();
    foreach (vec[v]) begin
      step(0, vec[v].s, vec[v].sl, vec[v].i, vec[v].d);
      check($sformatf("table_%0d", v), {field, decasec, sec, decamin, min, decahr, hr},
            {vec[v].f, bcd2(vec[v].sec), bcd2(vec[v].min), disp_hr(vec[v].hr)});
    end

    // Full-day rollover; in 12-hour builds also 11 AM -> 12 PM.
    preload_and_roll(1, 0);
`ifdef TWELVE_HOUR_EN
    preload_and_roll(13, 12);
`endif

    // Blink period while holding set mode.
    do_reset();
    step(0, 1, 0, 0, 0);
    prev = blink; seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      step(0, 1, 0, 0, 0);
      if (blink !== prev) seen = 1;
    end
    check("blink_first_toggle", seen, 1'b1);
    for (int p = 0; p < 2; p++) begin
      prev = blink; seen = 0; n = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
        step(0, 1, 0, 0, 0);
        n++;
        if (blink !== prev) seen = 1;
      end
      check("blink_period", n, 250);
    end
    step(0, 0, 0, 0, 0);
    check("blink_off_in_run", blink, 1'b0);

    // Reset in the middle of an adjustment.
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("reset_mid_adjust", {dut_digits(), field}, {disp_hr(0), 24'h0, 2'b00});

    // Randomized traffic against the model.
    do_reset();
    cur_s = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(49) == 0) cur_s = !cur_s;
      step($urandom_range(299) == 0, cur_s, $urandom_range(3) == 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
